kst_time_counter: RTL

- Master KST timekeeper that sits directly upstream of the world-time hour converter.
- Divides the system clock to a 1 Hz tick and maintains KST hours, minutes and seconds.
- Provides a button-driven set mode for hours and minutes.
- hour_kst feeds the converter's hour_kst input; min and sec go straight to the display path, because all supported zones are whole-hour offsets.

---
 rtl/kst_time_counter.sv | 116 +++++++++++
 1 files changed

// File: rtl/kst_time_counter.sv
// KST timekeeper: divides clk to a 1 Hz tick and keeps hour/min/sec.
// Also provides a button-driven set mode for hours and minutes.
//
//   state    | meaning
//   RUN      | time advances on each prescaler tick
//   SET_HOUR | time frozen, btn_inc steps hour_kst
//   SET_MIN  | time frozen, btn_inc steps min; leaving zeroes sec and prescaler
module kst_time_counter #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hour_kst,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick,
  output logic [1:0] set_mode,
  output logic       blink
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PS_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PS_HALF = PW'(CLK_HZ / 2);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          leave_set;

  assign tick      = (prescaler == PS_MAX);
  assign leave_set = (state == SET_MIN) && btn_mode;
  assign set_mode  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (btn_mode) state_nxt = SET_HOUR;
      SET_HOUR: if (btn_mode) state_nxt = SET_MIN;
      SET_MIN:  if (btn_mode) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Restarting on set-mode exit makes the first tick land a full second later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (leave_set || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_kst <= 5'd0;
      min      <= 6'd0;
      sec      <= 6'd0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      if (state == RUN) begin
        if (tick) begin
          sec_tick <= 1'b1;
          if (sec == 6'd59) begin
            sec <= 6'd0;
            if (min == 6'd59) begin
              min      <= 6'd0;
              hour_kst <= (hour_kst == 5'd23) ? 5'd0 : hour_kst + 5'd1;
            end else begin
              min <= min + 6'd1;
            end
          end else begin
            sec <= sec + 6'd1;
          end
        end
      end else if (state == SET_HOUR) begin
        if (btn_inc && !btn_mode) begin
          hour_kst <= (hour_kst == 5'd23) ? 5'd0 : hour_kst + 5'd1;
        end
      end else if (state == SET_MIN) begin
        if (btn_mode) begin
          sec <= 6'd0;
        end else if (btn_inc) begin
          min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
        end
      end
    end
  end

  // Gate with the next state so blink is already low in the first RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink <= 1'b0;
    end else begin
      blink <= (state_nxt != RUN) && (prescaler < PS_HALF);
    end
  end

endmodule
